store_stream_checker: RTL and testbench
=======================================

Name: store_stream_checker

Overview:
- Responder-side consumer of the CPU data-memory write stream (memwrite, dataadr, writedata) in the single-cycle MIPS top.
- Compares every committed store against an expected sequence held in an internal FIFO, which the bench or a host loads through a valid/ready port.
- Reports pass/fail, mismatch details and timeout in hardware, replacing ad-hoc negedge checks in benches.
- Sits beside dmem and snoops the same bus; never drives the bus.

Parameters:
- DEPTH, 16, expected-entry FIFO depth; power of two, minimum 2.
- TIMEOUT, 1000, max clk cycles in RUN with no counted store before fail; 0 disables the timeout.
- IGNORE_EN, 1, when 1, stores to IGNORE_ADR are dropped silently.
- IGNORE_ADR, 3'd0, address excluded from checking when IGNORE_EN=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  CPU store strobe; one store per cycle it is high.
- dataadr  input  3  CPU store address.
- writedata  input  8  CPU store data.
- exp_valid  input  1  expected-entry offered.
- exp_ready  output  1  FIFO not full.
- exp_adr  input  3  expected address.
- exp_data  input  8  expected data.
- exp_last  input  1  marks the final expected store of the sequence.
- arm  input  1  single-cycle pulse: IDLE -> RUN.
- running  output  1  state==RUN.
- pass  output  1  sticky success.
- fail  output  1  sticky failure.
- fail_code  output  2  00 none, 01 data/address mismatch, 10 unexpected store (FIFO empty), 11 timeout.
- bad_adr  output  3  dataadr of the failing store; 0 on timeout.
- bad_data  output  8  writedata of the failing store; 0 on timeout.
- store_count  output  8  matched stores since arm; saturates at 255.

Behaviour:
- Reset (async, high): state=IDLE, FIFO emptied, all outputs 0 except exp_ready=1.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL hold until reset; arm is ignored in those states.
- FIFO load:
  - An entry {adr, data, last} is pushed on a rising edge with exp_valid && exp_ready, in any state except FAIL.
  - exp_ready = !full, combinational.
- IDLE: memwrite is ignored. arm=1 -> RUN next cycle; timeout counter cleared; store_count cleared.
- RUN, store sampled on a rising edge with memwrite=1:
  - If IGNORE_EN and dataadr==IGNORE_ADR: no action.
  - Else if FIFO empty: FAIL, code 10.
  - Else pop the head.
    - Head adr/data match: store_count++.
    - Match and head.last=1: PASS.
    - Mismatch: FAIL, code 01.
  - Any counted store, match or mismatch, clears the timeout counter.
- Timeout, RUN only:
  - The counter increments every cycle with no counted store.
  - When it reaches TIMEOUT: FAIL, code 11.
  - A store arriving in the same cycle takes priority over the timeout.
- bad_adr/bad_data are captured on the failing edge and held.
- pass/fail/running are registered and valid the cycle after the deciding edge (latency 1).
- Simultaneous push and pop in the same cycle:
  - Both happen; occupancy is unchanged.
  - A push into an empty FIFO is not visible to a pop in the same cycle, so that store fails with code 10.
  - A push is allowed when full only if a pop occurs in the same cycle. exp_ready still reads 0, and a bench must not rely on this.
- Pointers are log2(DEPTH)+1 bits wide; full/empty are derived from the MSB compare and wrap naturally.
- Reset mid-RUN aborts immediately: FIFO cleared, no pass/fail asserted.
- The checker never back-pressures the CPU; memwrite has no ready.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE, ST_RUN, ST_PASS, ST_FAIL);
  - fail codes (FC_NONE, FC_MISMATCH, FC_UNEXPECTED, FC_TIMEOUT);
  - entry width constant (12 bits: 3 adr + 8 data + 1 last).
- One sub-module: sync_fifo (parameterised width/depth, async high reset, push/pop/full/empty), instantiated with width 12.
- Checker FSM, timeout counter and capture registers stay in the top module.

Test Plan:
- Push (7,28,0),(4,5,1); arm; stores (7,28),(4,5) on consecutive cycles -> pass=1 the cycle after the second store, store_count=2, fail=0.
- Push (7,28,1); arm; store (7,29) -> fail=1, fail_code=01, bad_adr=7, bad_data=29, pass stays 0.
- Arm with empty FIFO; store (3,9) -> fail_code=10, bad_adr=3, bad_data=9.
- IGNORE_EN=1, IGNORE_ADR=0:
  - Push (5,1,1); arm; store (0,80) then (5,1) -> pass=1, store_count=1.
  - Separately, in IDLE with no arm, stores produce no response.
- TIMEOUT=20; push (1,1,1); arm; no stores -> fail_code=11 exactly 20 cycles after RUN entry; bad_adr=0, bad_data=0.
- DEPTH=4: fill 4 entries -> exp_ready=0.
  - arm; match one store -> exp_ready=1.
  - Assert reset mid-RUN -> all outputs 0, exp_ready=1.
  - Re-load, re-arm, full sequence -> pass.

Source files
------------

// File: rtl/store_stream_checker_pkg.sv
// Shared definitions for the store stream checker.
//   - state_t : checker FSM states
//   - fcode_t : fail_code encoding reported on the fail_code port
//   - entry_t : one expected store {adr, data, last}, ENTRY_W bits wide
package store_stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_MISMATCH   = 2'b01,
    FC_UNEXPECTED = 2'b10,
    FC_TIMEOUT    = 2'b11
  } fcode_t;

  localparam int ADR_W   = 3;
  localparam int DAT_W   = 8;
  localparam int ENTRY_W = ADR_W + DAT_W + 1;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] data;
    logic             last;
  } entry_t;

endpackage

// File: rtl/store_stream_checker_fifo.sv
// Synchronous FIFO holding expected store entries.
//   clk, reset : clock, asynchronous active-high reset (pointers only)
//   push, din  : write request and data (accepted when not full, or when a
//                pop happens in the same cycle)
//   pop, dout  : read request and head-of-queue data (show-ahead)
//   full, empty: occupancy flags from the extra-MSB pointer compare
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot on this edge, so a push into a full FIFO is safe then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/store_stream_checker.sv
// Snoops the CPU data-memory write stream and compares every committed store
// against an expected sequence loaded into an internal FIFO.
//   clk, reset                  : clock, asynchronous active-high reset
//   memwrite, dataadr, writedata: snooped CPU store bus (never driven)
//   exp_valid/exp_ready, exp_adr, exp_data, exp_last: expected-entry load port
//   arm                         : starts checking (IDLE -> RUN)
//   running, pass, fail         : state flags, sticky pass/fail
//   fail_code, bad_adr, bad_data: failure reason and offending store
//   store_count                 : matched stores since arm, saturating
module store_stream_checker #(
  parameter int         DEPTH      = 16,
  parameter int         TIMEOUT    = 1000,
  parameter int         IGNORE_EN  = 1,
  parameter logic [2:0] IGNORE_ADR = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memwrite,
  input  logic [2:0] dataadr,
  input  logic [7:0] writedata,
  input  logic       exp_valid,
  output logic       exp_ready,
  input  logic [2:0] exp_adr,
  input  logic [7:0] exp_data,
  input  logic       exp_last,
  input  logic       arm,
  output logic       running,
  output logic       pass,
  output logic       fail,
  output logic [1:0] fail_code,
  output logic [2:0] bad_adr,
  output logic [7:0] bad_data,
  output logic [7:0] store_count
);

  import store_stream_checker_pkg::*;

  localparam int            TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        state;
  state_t        state_nxt;
  fcode_t        fc_q;
  fcode_t        code_nxt;
  logic [TW-1:0] tcnt;
  entry_t        head;
  entry_t        wentry;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          hit;
  logic          tclr;
  logic          tinc;
  logic          cnt_clr;
  logic          cap;
  logic          cap_store;
  logic          store_seen;

  assign wentry     = '{adr: exp_adr, data: exp_data, last: exp_last};
  assign exp_ready  = !full;
  assign store_seen = memwrite && !((IGNORE_EN != 0) && (dataadr == IGNORE_ADR));
  // Pop is decided from the registered empty flag, so an entry pushed on the
  // same edge cannot satisfy a store arriving on that edge.
  assign push       = exp_valid && (state != ST_FAIL) && (!full || pop);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wentry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    code_nxt  = FC_NONE;
    pop       = 1'b0;
    hit       = 1'b0;
    tclr      = 1'b0;
    tinc      = 1'b0;
    cnt_clr   = 1'b0;
    cap       = 1'b0;
    cap_store = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          state_nxt = ST_RUN;
          tclr      = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        // A counted store always wins over a timeout on the same edge.
        if (store_seen) begin
          tclr = 1'b1;
          if (empty) begin
            state_nxt = ST_FAIL;
            code_nxt  = FC_UNEXPECTED;
            cap       = 1'b1;
            cap_store = 1'b1;
          end else begin
            pop = 1'b1;
            if ((head.adr == dataadr) && (head.data == writedata)) begin
              hit = 1'b1;
              if (head.last) state_nxt = ST_PASS;
            end else begin
              state_nxt = ST_FAIL;
              code_nxt  = FC_MISMATCH;
              cap       = 1'b1;
              cap_store = 1'b1;
            end
          end
        end else if ((TIMEOUT != 0) && (tcnt == TLIM - TW'(1))) begin
          state_nxt = ST_FAIL;
          code_nxt  = FC_TIMEOUT;
          cap       = 1'b1;
        end else begin
          tinc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      fc_q        <= FC_NONE;
      tcnt        <= '0;
      store_count <= '0;
      bad_adr     <= '0;
      bad_data    <= '0;
    end else begin
      state <= state_nxt;
      if (tclr)      tcnt <= '0;
      else if (tinc) tcnt <= tcnt + TW'(1);
      if (cnt_clr)   store_count <= '0;
      else if (hit)  store_count <= sat_inc8(store_count);
      if (cap) begin
        fc_q     <= code_nxt;
        bad_adr  <= cap_store ? dataadr : 3'd0;
        bad_data <= cap_store ? writedata : 8'd0;
      end
    end
  end

  assign running   = (state == ST_RUN);
  assign pass      = (state == ST_PASS);
  assign fail      = (state == ST_FAIL);
  assign fail_code = fc_q;

endmodule

// File: tb/tb_store_stream_checker.sv
// Self-checking bench for store_stream_checker (DEPTH=4, TIMEOUT=20,
// stores to address 0 ignored). A queue-based reference model tracks the
// expected outputs; a negedge process compares them every cycle, and
// directed scenarios add hand-computed literal checks.
module tb_store_stream_checker;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

  typedef struct packed {
    logic [2:0] adr;
    logic [7:0] data;
    logic       last;
  } ment_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       memwrite = 1'b0;
  logic [2:0] dataadr = '0;
  logic [7:0] writedata = '0;
  logic       exp_valid = 1'b0;
  logic       exp_ready;
  logic [2:0] exp_adr = '0;
  logic [7:0] exp_data = '0;
  logic       exp_last = 1'b0;
  logic       arm = 1'b0;
  logic       running, pass, fail;
  logic [1:0] fail_code;
  logic [2:0] bad_adr;
  logic [7:0] bad_data;
  logic [7:0] store_count;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_stream_checker #(
    .DEPTH      (DEPTH),
    .TIMEOUT    (TMO),
    .IGNORE_EN  (1),
    .IGNORE_ADR (3'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .exp_valid   (exp_valid),
    .exp_ready   (exp_ready),
    .exp_adr     (exp_adr),
    .exp_data    (exp_data),
    .exp_last    (exp_last),
    .arm         (arm),
    .running     (running),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code),
    .bad_adr     (bad_adr),
    .bad_data    (bad_data),
    .store_count (store_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: expected entries in a queue, outcome from the rules.
  ment_t      mq[$];
  int         m_mode = M_IDLE;
  int         m_code = 0;
  int         m_cnt = 0;
  int         m_idle = 0;
  logic [2:0] m_badadr = '0;
  logic [7:0] m_baddata = '0;
  int         m_prev;
  int         m_occ;
  bit         m_popped;
  ment_t      m_h;

  task automatic m_fail(input int code, input logic [2:0] a, input logic [7:0] d);
    m_mode = M_FAIL; m_code = code; m_badadr = a; m_baddata = d;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_mode = M_IDLE; m_code = 0; m_cnt = 0; m_idle = 0;
      m_badadr = '0; m_baddata = '0;
    end else begin
      m_prev = m_mode;
      m_occ = mq.size();
      m_popped = 1'b0;
      if (m_mode == M_RUN) begin
        if (memwrite && dataadr != 3'd0) begin
          m_idle = 0;
          if (m_occ == 0) m_fail(2, dataadr, writedata);
          else begin
            m_h = mq.pop_front();
            m_popped = 1'b1;
            if (m_h.adr == dataadr && m_h.data == writedata) begin
              if (m_cnt < 255) m_cnt++;
              if (m_h.last) m_mode = M_PASS;
            end else m_fail(1, dataadr, writedata);
          end
        end else begin
          m_idle++;
          if (m_idle == TMO) m_fail(3, 3'd0, 8'd0);
        end
      end else if (m_mode == M_IDLE && arm) begin
        m_mode = M_RUN; m_cnt = 0; m_idle = 0;
      end
      if (exp_valid && m_prev != M_FAIL && (m_occ < DEPTH || m_popped))
        mq.push_back('{adr: exp_adr, data: exp_data, last: exp_last});
    end
  end

  always @(negedge clk) begin
    chk("running",     running,     m_mode == M_RUN);
    chk("pass",        pass,        m_mode == M_PASS);
    chk("fail",        fail,        m_mode == M_FAIL);
    chk("fail_code",   fail_code,   m_code);
    chk("bad_adr",     bad_adr,     m_badadr);
    chk("bad_data",    bad_data,    m_baddata);
    chk("store_count", store_count, m_cnt);
    chk("exp_ready",   exp_ready,   mq.size() < DEPTH);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memwrite = 0; exp_valid = 0; arm = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d, input logic l);
    exp_valid = 1; exp_adr = a; exp_data = d; exp_last = l;
    step();
    exp_valid = 0;
  endtask

  task automatic store(input logic [2:0] a, input logic [7:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    step();
    memwrite = 0;
  endtask

  task automatic do_arm();
    arm = 1; step(); arm = 0;
  endtask

  int mw_pct;

  initial begin
    step(); step();
    do_reset();
    chk("rst_running", running, 0);
    chk("rst_ready", exp_ready, 1);
    chk("rst_code", fail_code, 0);

    // Two-entry sequence, matched on consecutive cycles.
    push(3'd7, 8'd28, 1'b0);
    push(3'd4, 8'd5, 1'b1);
    do_arm();
    chk("t1_running", running, 1);
    memwrite = 1; dataadr = 3'd7; writedata = 8'd28; step();
    dataadr = 3'd4; writedata = 8'd5; step();
    memwrite = 0;
    chk("t1_pass", pass, 1);
    chk("t1_count", store_count, 2);
    chk("t1_fail", fail, 0);
    chk("t1_model_pass", m_mode == M_PASS, 1);

    // Data mismatch.
    do_reset();
    push(3'd7, 8'd28, 1'b1);
    do_arm();
    store(3'd7, 8'd29);
    chk("t2_fail", fail, 1);
    chk("t2_code", fail_code, 1);
    chk("t2_bad_adr", bad_adr, 7);
    chk("t2_bad_data", bad_data, 29);
    chk("t2_pass", pass, 0);
    chk("t2_model_code", m_code, 1);

    // Store with empty FIFO.
    do_reset();
    do_arm();
    store(3'd3, 8'd9);
    chk("t3_code", fail_code, 2);
    chk("t3_bad_adr", bad_adr, 3);
    chk("t3_bad_data", bad_data, 9);

    // Ignored address.
    do_reset();
    push(3'd5, 8'd1, 1'b1);
    do_arm();
    store(3'd0, 8'd80);
    chk("t4_running", running, 1);
    chk("t4_count0", store_count, 0);
    store(3'd5, 8'd1);
    chk("t4_pass", pass, 1);
    chk("t4_count", store_count, 1);

    // Stores in IDLE without arm do nothing.
    do_reset();
    for (int i = 0; i < 3; i++) store(3'(i + 1), 8'(i * 7));
    chk("t4b_running", running, 0);
    chk("t4b_fail", fail, 0);
    chk("t4b_count", store_count, 0);

    // Timeout exactly TMO cycles after RUN entry.
    do_reset();
    push(3'd1, 8'd1, 1'b1);
    do_arm();
    chk("t5_running", running, 1);
    repeat (TMO - 1) step();
    chk("t5_fail_early", fail, 0);
    step();
    chk("t5_fail", fail, 1);
    chk("t5_code", fail_code, 3);
    chk("t5_bad_adr", bad_adr, 0);
    chk("t5_bad_data", bad_data, 0);

    // Full FIFO, reset mid-run, reload and pass.
    do_reset();
    for (int i = 1; i <= 4; i++) push(3'(i), 8'(i * 10), i == 4);
    chk("t6_full", exp_ready, 0);
    do_arm();
    store(3'd1, 8'd10);
    chk("t6_ready", exp_ready, 1);
    chk("t6_count", store_count, 1);
    reset = 1;
    #1;
    chk("t6_rst_running", running, 0);
    chk("t6_rst_count", store_count, 0);
    chk("t6_rst_ready", exp_ready, 1);
    chk("t6_rst_fail", fail, 0);
    step();
    reset = 0;
    for (int i = 1; i <= 4; i++) push(3'(i), 8'(i * 10), i == 4);
    do_arm();
    for (int i = 1; i <= 4; i++) store(3'(i), 8'(i * 10));
    chk("t6_pass", pass, 1);
    chk("t6_count4", store_count, 4);

    // Randomized rounds against the model.
    for (int r = 0; r < 30; r++) begin
      do_reset();
      mw_pct = (r % 5 == 4) ? 0 : 4;
      for (int c = 0; c < 60; c++) begin
        exp_valid = ($urandom_range(0, 9) < 4);
        exp_adr   = 3'($urandom_range(1, 7));
        exp_data  = 8'($urandom);
        exp_last  = ($urandom_range(0, 3) == 0);
        arm       = ($urandom_range(0, 9) == 0);
        memwrite  = ($urandom_range(0, 9) < mw_pct);
        if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
          dataadr   = mq[0].adr;
          writedata = mq[0].data;
        end else begin
          dataadr   = 3'($urandom_range(0, 7));
          writedata = 8'($urandom);
        end
        step();
      end
      idle_inputs();
    end

    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
